// File: rtl/onehot_mux_reg.sv
// onehot_mux_reg: one-hot AND-OR 2/4-way muxes with registered copies; ONEHOT_CHECK_EN adds select-legality flag sel_err
module onehot_mux_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel2,
  input  logic [WIDTH-1:0] d2_1,
  input  logic [WIDTH-1:0] d2_0,
  input  logic [3:0]       sel4,
  input  logic [WIDTH-1:0] d4_3,
  input  logic [WIDTH-1:0] d4_2,
  input  logic [WIDTH-1:0] d4_1,
  input  logic [WIDTH-1:0] d4_0,
  output logic [WIDTH-1:0] m2,
  output logic [WIDTH-1:0] m4,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q4,
  output logic             sel_err
);
  logic [WIDTH-1:0] q2_q, q2_d, q4_q, q4_d;
  always_comb begin
    m2 = ({WIDTH{sel2[1]}} & d2_1) | ({WIDTH{sel2[0]}} & d2_0);
    m4 = ({WIDTH{sel4[3]}} & d4_3) | ({WIDTH{sel4[2]}} & d4_2)
       | ({WIDTH{sel4[1]}} & d4_1) | ({WIDTH{sel4[0]}} & d4_0);
    q2_d = m2;
    q4_d = m4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q2_q <= '0;
      q4_q <= '0;
    end else begin
      q2_q <= q2_d;
      q4_q <= q4_d;
    end
  end
  assign q2 = q2_q;
  assign q4 = q4_q;
`ifdef ONEHOT_CHECK_EN
  logic sel_err_q, sel_err_d;
  always_comb
    sel_err_d = !(sel2[0] ^ sel2[1]) || (sel4 == 4'd0) || ((sel4 & (sel4 - 4'd1)) != 4'd0);
  always_ff @(posedge clk) sel_err_q <= rst ? 1'b0 : sel_err_d;
  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_onehot_mux_reg.sv
// tb_onehot_mux_reg: table-driven check of onehot_mux_reg (WIDTH=9 and WIDTH=1 instances)
module tb_onehot_mux_reg;
`ifdef ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] sel2;
  logic [3:0] sel4;
  logic [8:0] d2_1, d2_0, d4_3, d4_2, d4_1, d4_0, m2, m4, q2, q4;
  logic sel_err;
  logic [1:0] w_sel2;
  logic [3:0] w_sel4;
  logic w_d2_1, w_d2_0, w_d4_3, w_d4_2, w_d4_1, w_d4_0, w_m2, w_m4, w_q2, w_q4, w_err;
  int n_cmp = 0, n_fail = 0;

  onehot_mux_reg #(.WIDTH(9)) dut (
    .clk(clk), .rst(rst), .sel2(sel2), .d2_1(d2_1), .d2_0(d2_0), .sel4(sel4),
    .d4_3(d4_3), .d4_2(d4_2), .d4_1(d4_1), .d4_0(d4_0),
    .m2(m2), .m4(m4), .q2(q2), .q4(q4), .sel_err(sel_err)
  );
  onehot_mux_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .sel2(w_sel2), .d2_1(w_d2_1), .d2_0(w_d2_0), .sel4(w_sel4),
    .d4_3(w_d4_3), .d4_2(w_d4_2), .d4_1(w_d4_1), .d4_0(w_d4_0),
    .m2(w_m2), .m4(w_m4), .q2(w_q2), .q4(w_q4), .sel_err(w_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel2;
    logic [8:0] d2_1, d2_0;
    logic [3:0] sel4;
    logic [8:0] d4_3, d4_2, d4_1, d4_0;
    logic [8:0] exp_m2, exp_m4;
    logic       illegal;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'b01, 9'h0F0, 9'h00F, 4'b0001, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h00F, 9'h100, 1'b0};
    vecs[1] = '{2'b10, 9'h0F0, 9'h00F, 4'b0010, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h0F0, 9'h00F, 1'b0};
    vecs[2] = '{2'b11, 9'h0F0, 9'h00F, 4'b0100, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h0FF, 9'h0F0, 1'b1};
    vecs[3] = '{2'b00, 9'h0F0, 9'h00F, 4'b1000, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h000, 9'h1A5, 1'b1};
    vecs[4] = '{2'b01, 9'h0F0, 9'h00F, 4'b0110, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h00F, 9'h0FF, 1'b1};
    vecs[5] = '{2'b01, 9'h0F0, 9'h00F, 4'b0100, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h00F, 9'h0F0, 1'b0};
    vecs[6] = '{2'b10, 9'h0F0, 9'h00F, 4'b0000, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h0F0, 9'h000, 1'b1};
    vecs[7] = '{2'b01, 9'h0F0, 9'h00F, 4'b1111, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h00F, 9'h1FF, 1'b1};
    vecs[8] = '{2'b10, 9'h0F0, 9'h00F, 4'b0001, 9'h1A5, 9'h0F0, 9'h00F, 9'h100, 9'h0F0, 9'h100, 1'b0};
    vecs[9] = '{2'b11, 9'h1AA, 9'h055, 4'b1001, 9'h0C3, 9'h111, 9'h122, 9'h030, 9'h1FF, 9'h0F3, 1'b1};
    w_sel2 = 2'b01; w_d2_1 = 1'b0; w_d2_0 = 1'b1;
    w_sel4 = 4'b0010; w_d4_3 = 1'b0; w_d4_2 = 1'b0; w_d4_1 = 1'b1; w_d4_0 = 1'b0;
    // Reset with non-one-hot selects: registers and sel_err must clear, muxes stay live
    sel2 = 2'b11; d2_1 = 9'h1F0; d2_0 = 9'h00E;
    sel4 = 4'b0000; d4_3 = 9'h1A5; d4_2 = 9'h0F0; d4_1 = 9'h00F; d4_0 = 9'h100;
    tick();
    chk("rst_q2", q2, 9'h000);
    chk("rst_q4", q4, 9'h000);
    chk("rst_err", {8'd0, sel_err}, 9'h000);
    chk("rst_m2", m2, 9'h1FE);
    chk("rst_m4", m4, 9'h000);
    chk("rst_w_q4", {8'd0, w_q4}, 9'h000);
    rst = 1'b0;
    foreach (vecs[i]) begin
      sel2 = vecs[i].sel2; d2_1 = vecs[i].d2_1; d2_0 = vecs[i].d2_0;
      sel4 = vecs[i].sel4; d4_3 = vecs[i].d4_3; d4_2 = vecs[i].d4_2;
      d4_1 = vecs[i].d4_1; d4_0 = vecs[i].d4_0;
      #1;
      chk($sformatf("v%0d_m2", i), m2, vecs[i].exp_m2);
      chk($sformatf("v%0d_m4", i), m4, vecs[i].exp_m4);
      tick();
      chk($sformatf("v%0d_q2", i), q2, vecs[i].exp_m2);
      chk($sformatf("v%0d_q4", i), q4, vecs[i].exp_m4);
      chk($sformatf("v%0d_err", i), {8'd0, sel_err}, {8'd0, CHK & vecs[i].illegal});
    end
    // Hold loop: load 0x123, then recirculate q4 through d4_3
    sel2 = 2'b01; d2_0 = 9'h055; sel4 = 4'b0100; d4_2 = 9'h123;
    tick();
    chk("hold_load", q4, 9'h123);
    sel4 = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      d4_3 = q4;
      tick();
      chk($sformatf("hold_%0d", i), q4, 9'h123);
    end
    rst = 1'b1;
    d4_3 = q4;
    #1;
    chk("hold_rst_m4", m4, 9'h123);
    tick();
    chk("hold_rst_q4", q4, 9'h000);
    chk("hold_rst_q2", q2, 9'h000);
    rst = 1'b0;
    sel4 = 4'b0001; d4_0 = 9'h0AB;
    tick();
    chk("resume_q4", q4, 9'h0AB);
    chk("resume_q2", q2, 9'h055);
    // Error flag set by overlap then cleared by a legal select
    sel4 = 4'b0110;
    tick();
    chk("err_set", {8'd0, sel_err}, {8'd0, CHK});
    sel4 = 4'b0100;
    tick();
    chk("err_clr", {8'd0, sel_err}, 9'h000);
    // WIDTH=1 decoder walk
    for (int k = 0; k < 4; k++) begin
      w_sel4 = 4'b0001 << k;
      #1;
      chk($sformatf("w1_m4_%0d", k), {8'd0, w_m4}, {8'd0, k == 1});
    end
    chk("w1_m2", {8'd0, w_m2}, 9'h001);
    tick();
    chk("w1_q4", {8'd0, w_q4}, 9'h000);
    w_sel4 = 4'b0010;
    tick();
    chk("w1_q4b", {8'd0, w_q4}, 9'h001);
    chk("w1_err", {8'd0, w_err}, 9'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/onehot_mux_reg.md
Name: onehot_mux_reg

Overview:
- Parameterised datapath cell built from the shared primitives: a 2-input one-hot AND-OR mux, a 4-input one-hot AND-OR mux, and a WIDTH-bit register stage.
- Saturation and ammo counters, plus mode decoders, use it as the standard select-then-register element.
- Both mux outputs are available combinationally and as registered copies.
- The register has a synchronous active-high clear.

Parameters:
- WIDTH, 9, data width of every data input, mux output and register.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous active-high reset; clears all registers on the next clk edge
- sel2  input  2  one-hot select for 2-way mux; bit0 selects d2_0, bit1 selects d2_1
- d2_1  input  WIDTH  2-way mux data input 1
- d2_0  input  WIDTH  2-way mux data input 0
- sel4  input  4  one-hot select for 4-way mux; bit k selects d4_k
- d4_3  input  WIDTH  4-way mux data input 3
- d4_2  input  WIDTH  4-way mux data input 2
- d4_1  input  WIDTH  4-way mux data input 1
- d4_0  input  WIDTH  4-way mux data input 0
- m2  output  WIDTH  combinational 2-way mux result
- m4  output  WIDTH  combinational 4-way mux result
- q2  output  WIDTH  registered m2
- q4  output  WIDTH  registered m4
- sel_err  output  1  registered select-legality flag (see Optional Feature)

Behaviour:
- Clock and reset are fixed: one clock (clk); rst is synchronous and active-high.

Mux semantics (pure AND-OR, no priority):
- m2 = (sel2[1] ? d2_1 : 0) | (sel2[0] ? d2_0 : 0).
- m4 = OR over k=0..3 of (sel4[k] ? d4_k : 0).
- All-zero select -> result 0.
- Multiple select bits high -> bitwise OR of all selected inputs. This is legal and deterministic; no X is produced.
- 1-bit use (WIDTH=1) works identically; mode decoders rely on this. Example: sel4=4'b0010 with d4_1=1 and all other inputs 0 gives m4=1.

Register stage:
- Every rising clk edge: if rst=1, then q2, q4 and sel_err go to 0; otherwise q2<=m2, q4<=m4, and sel_err takes its next value.
- Latency is exactly 1 cycle from inputs to q2/q4.
- There is no enable. Hold behaviour comes from feeding q back into a data input and selecting it, e.g. d4_3=q4 with sel4=4'b1000.
- Reset mid-operation: the next edge zeroes the registers regardless of the selects. Registered values resume the cycle after rst deasserts.
- The registers are undefined before the first clk edge with rst=1. Benches must apply reset first.
- m2 and m4 are unaffected by rst; they are combinational only.

Width and arithmetic:
- No arithmetic; all paths are bit-wise.
- No truncation or extension; all data is exactly WIDTH bits.

Optional Feature:
- Macro ONEHOT_CHECK_EN.
- Defined: sel_err registers 1 on any edge (rst=0) where sel2 or sel4 is not exactly one-hot, i.e. zero bits set or more than one bit set. It clears when both selects are one-hot on a later edge. rst forces it to 0.
- Undefined: the checking logic is omitted and sel_err is tied constant 0. The port still exists, so the interface is identical. Mux behaviour is unchanged either way.

Test Plan:
- Reset: hold rst=1 one edge with arbitrary inputs -> q2=0, q4=0, sel_err=0 after the edge. m2 and m4 still follow their inputs.
- 4-way select walk, WIDTH=9, d4_3=9'h1A5, d4_2=9'h0F0, d4_1=9'h00F, d4_0=9'h100. Apply sel4=0001, 0010, 0100, 1000 in turn -> m4=100, 00F, 0F0, 1A5 immediately, and q4 shows the same values one cycle later.
- 2-way and overlap: d2_1=9'h0F0, d2_0=9'h00F. sel2=01 gives m2=00F; sel2=10 gives 0F0; sel2=11 gives 0FF; sel2=00 gives 000.
- Hold loop: d4_3=q4 and sel4=1000 for 5 cycles after loading 9'h123 via sel4=0100 -> q4 stays 9'h123. Asserting rst mid-hold gives q4=0 on the next edge.
- ONEHOT_CHECK_EN defined: sel4=0110 for one edge gives sel_err=1. sel4=0100 on the next edge gives sel_err=0. With the macro undefined, the same stimulus gives sel_err=0 always.
- WIDTH=1 decoder: d4_3..d4_0=0,0,1,0 and sel4=0010 -> m4=1. Every other one-hot sel4 gives m4=0.
